// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the core in reset after rst, then counts run
// cycles until a masked done request or the watchdog ends the run.
module sim_run_ctrl #(
  parameter int unsigned RST_CYCLES      = 25,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned REPORT_INTERVAL = 10000,
  parameter int unsigned MAX_CYCLES      = 150000000,
  parameter int unsigned N_SRC           = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] done_req,
  input  logic [N_SRC-1:0] done_mask,
  output logic             core_rst,
  output logic             running,
  output logic [CNT_W-1:0] cycles,
  output logic             tick,
  output logic             finished,
  output logic             timeout,
  output logic [N_SRC-1:0] done_src
);

  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned RPT_W  = (REPORT_INTERVAL > 1) ? $clog2(REPORT_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {HOLD, RUN, DONE, TOUT} state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [RPT_W-1:0]  rpt_cnt, rpt_nxt;
  logic [CNT_W-1:0]  cycles_nxt;
  logic              tick_nxt, finished_nxt, timeout_nxt;
  logic [N_SRC-1:0]  done_src_nxt, hit;

  assign hit = done_req & done_mask;

  // Next state and next values of all registered outputs
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    rpt_nxt      = rpt_cnt;
    cycles_nxt   = cycles;
    tick_nxt     = 1'b0;
    finished_nxt = finished;
    timeout_nxt  = timeout;
    done_src_nxt = done_src;
    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      RUN: begin
        // Saturated counter also freezes the progress divider
        if (cycles != CNT_MAX) begin
          cycles_nxt = cycles + CNT_W'(1);
          if (REPORT_INTERVAL != 0) begin
            if (rpt_cnt == RPT_W'(REPORT_INTERVAL - 1)) begin
              rpt_nxt  = '0;
              tick_nxt = 1'b1;
            end else begin
              rpt_nxt = rpt_cnt + RPT_W'(1);
            end
          end
        end
        // A done request takes priority over a coincident watchdog expiry
        if (|hit) begin
          state_nxt    = DONE;
          finished_nxt = 1'b1;
          done_src_nxt = hit;
          tick_nxt     = 1'b0;
        end else if ((MAX_CYCLES != 0) && (cycles_nxt == CNT_W'(MAX_CYCLES))) begin
          state_nxt   = TOUT;
          timeout_nxt = 1'b1;
          tick_nxt    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      hold_cnt <= '0;
      rpt_cnt  <= '0;
      core_rst <= 1'b1;
      running  <= 1'b0;
      cycles   <= '0;
      tick     <= 1'b0;
      finished <= 1'b0;
      timeout  <= 1'b0;
      done_src <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      rpt_cnt  <= rpt_nxt;
      core_rst <= (state_nxt == HOLD);
      running  <= (state_nxt == RUN);
      cycles   <= cycles_nxt;
      tick     <= tick_nxt;
      finished <= finished_nxt;
      timeout  <= timeout_nxt;
      done_src <= done_src_nxt;
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: three instances cover defaults, a small
// run/done/watchdog configuration and a narrow saturating counter.
module tb_sim_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // u0: default parameters
  logic r0, cr0, run0, tk0, fin0, to0;
  logic [0:0] dr0, dm0, ds0;
  logic [31:0] cyc0;
  sim_run_ctrl u0 (
    .clk(clk), .rst(r0), .done_req(dr0), .done_mask(dm0), .core_rst(cr0),
    .running(run0), .cycles(cyc0), .tick(tk0), .finished(fin0), .timeout(to0),
    .done_src(ds0)
  );

  // u1: short hold, tick every 4, watchdog 20, three channels
  logic r1, cr1, run1, tk1, fin1, to1;
  logic [2:0] dr1, dm1, ds1;
  logic [15:0] cyc1;
  sim_run_ctrl #(.RST_CYCLES(3), .CNT_W(16), .REPORT_INTERVAL(4), .MAX_CYCLES(20), .N_SRC(3)) u1 (
    .clk(clk), .rst(r1), .done_req(dr1), .done_mask(dm1), .core_rst(cr1),
    .running(run1), .cycles(cyc1), .tick(tk1), .finished(fin1), .timeout(to1),
    .done_src(ds1)
  );

  // u2: 4-bit counter, no watchdog, no tick
  logic r2, cr2, run2, tk2, fin2, to2;
  logic [0:0] dr2, dm2, ds2;
  logic [3:0] cyc2;
  sim_run_ctrl #(.RST_CYCLES(2), .CNT_W(4), .REPORT_INTERVAL(0), .MAX_CYCLES(0), .N_SRC(1)) u2 (
    .clk(clk), .rst(r2), .done_req(dr2), .done_mask(dm2), .core_rst(cr2),
    .running(run2), .cycles(cyc2), .tick(tk2), .finished(fin2), .timeout(to2),
    .done_src(ds2)
  );

  // Count core_rst-high samples from release until running rises
  task automatic wait_run1(output int hi);
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      if (cr1) hi++;
      if (run1) break;
      @(negedge clk);
    end
  endtask

  task automatic restart1();
    r1  = 1'b1;
    dr1 = '0;
    @(negedge clk);
    r1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi, ovl, ticks;
    r0 = 1'b1; dr0 = '0; dm0 = 1'b1;
    r1 = 1'b1; dr1 = '0; dm1 = 3'b101;
    r2 = 1'b1; dr2 = '0; dm2 = 1'b1;
    repeat (10) @(negedge clk);

    check("rst_core_rst", 64'(cr0), 64'd1);
    check("rst_running", 64'(run0), 64'd0);
    check("rst_cycles", 64'(cyc0), 64'd0);
    check("rst_tick", 64'(tk0), 64'd0);
    check("rst_flags", 64'({fin0, to0, ds0}), 64'd0);

    // Default hold length
    r0 = 1'b0;
    hi = 0; ovl = 0;
    for (int i = 0; i < 100; i++) begin
      if (cr0) hi++;
      if (cr0 && run0) ovl++;
      if (run0) break;
      @(negedge clk);
    end
    check("hold25_len", 64'(hi), 64'd25);
    check("hold25_overlap", 64'(ovl), 64'd0);
    check("hold25_running", 64'(run0), 64'd1);
    check("hold25_core_rst", 64'(cr0), 64'd0);
    check("hold25_cycles", 64'(cyc0), 64'd0);

    // Progress ticks over 13 cycles; masked-out request at cycle 5 ignored
    r1 = 1'b0;
    wait_run1(hi);
    check("hold3_len", 64'(hi), 64'd3);
    ticks = 0;
    for (int k = 0; k < 13; k++) begin
      dr1 = (k == 5) ? 3'b010 : 3'b000;
      @(negedge clk);
      if (tk1) ticks++;
      check($sformatf("tick_at_%0d", k + 1), 64'(tk1), 64'(((k + 1) % 4) == 0));
    end
    dr1 = '0;
    check("tick_count", 64'(ticks), 64'd3);
    check("run13_cycles", 64'(cyc1), 64'd13);
    check("run13_running", 64'(run1), 64'd1);
    check("run13_finished", 64'(fin1), 64'd0);

    // Reset pulse mid-run at cycles=7
    restart1();
    wait_run1(hi);
    repeat (7) @(negedge clk);
    check("pre_pulse_cycles", 64'(cyc1), 64'd7);
    r1 = 1'b1;
    @(negedge clk);
    check("pulse_core_rst", 64'(cr1), 64'd1);
    check("pulse_running", 64'(run1), 64'd0);
    check("pulse_cycles", 64'(cyc1), 64'd0);
    check("pulse_flags", 64'({tk1, fin1, to1, ds1}), 64'd0);
    r1 = 1'b0;
    wait_run1(hi);
    check("pulse_hold_len", 64'(hi), 64'd3);
    check("pulse_restart_cycles", 64'(cyc1), 64'd0);

    // Done: masked-out request at 5, mixed request at 9 ends the run
    for (int k = 0; k < 30 && run1; k++) begin
      dr1 = (k == 5) ? 3'b010 : (k == 9) ? 3'b110 : 3'b000;
      @(negedge clk);
    end
    check("done_finished", 64'(fin1), 64'd1);
    check("done_timeout", 64'(to1), 64'd0);
    check("done_src", 64'(ds1), 64'h4);
    check("done_cycles", 64'(cyc1), 64'd10);
    check("done_running", 64'(run1), 64'd0);
    check("done_core_rst", 64'(cr1), 64'd0);
    dr1 = 3'b111;
    repeat (5) @(negedge clk);
    check("done_frozen_cycles", 64'(cyc1), 64'd10);
    check("done_frozen_src", 64'(ds1), 64'h4);
    dr1 = '0;

    // Watchdog expiry, then late requests ignored
    restart1();
    wait_run1(hi);
    for (int k = 0; k < 40 && run1; k++) @(negedge clk);
    check("tout_timeout", 64'(to1), 64'd1);
    check("tout_finished", 64'(fin1), 64'd0);
    check("tout_cycles", 64'(cyc1), 64'd20);
    check("tout_running", 64'(run1), 64'd0);
    check("tout_tick", 64'(tk1), 64'd0);
    dr1 = 3'b111;
    repeat (3) @(negedge clk);
    check("tout_late_finished", 64'(fin1), 64'd0);
    check("tout_late_src", 64'(ds1), 64'd0);
    check("tout_late_cycles", 64'(cyc1), 64'd20);

    // Done coincident with the watchdog limit
    restart1();
    wait_run1(hi);
    for (int k = 0; k < 40 && run1; k++) begin
      dr1 = (k == 19) ? 3'b001 : 3'b000;
      @(negedge clk);
    end
    check("tie_finished", 64'(fin1), 64'd1);
    check("tie_timeout", 64'(to1), 64'd0);
    check("tie_cycles", 64'(cyc1), 64'd20);
    check("tie_src", 64'(ds1), 64'h1);
    dr1 = '0;

    // Saturating 4-bit counter
    r2 = 1'b0;
    for (int i = 0; i < 20 && !run2; i++) @(negedge clk);
    check("sat_running_start", 64'(run2), 64'd1);
    ticks = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (tk2) ticks++;
    end
    check("sat_cycles", 64'(cyc2), 64'd15);
    check("sat_ticks", 64'(ticks), 64'd0);
    check("sat_timeout", 64'(to2), 64'd0);
    check("sat_running", 64'(run2), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
